// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared single-port program/data RAM: CPU (m0) and loader (m1).
// Round-robin by default; define ARB_CPU_PRIORITY_EN to give the CPU fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam int CNT_W = 3;

    state_t           state;
    logic             we_l;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             grant_m1;

    always_comb begin
        any_req = m0_req | m1_req;
`ifdef ARB_CPU_PRIORITY_EN
        grant_m1 = ~m0_req;
`else
        // On a tie the requester that was not served last wins.
        grant_m1 = m1_req & (~m0_req | ~last_grant);
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            we_l       <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            owner      <= 1'b0;
            busy       <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant_m1;
                        last_grant <= grant_m1;
                        we_l       <= grant_m1 ? m1_we    : m0_we;
                        ram_we     <= grant_m1 ? m1_we    : m0_we;
                        ram_addr   <= grant_m1 ? m1_addr  : m0_addr;
                        ram_wdata  <= grant_m1 ? m1_wdata : m0_wdata;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_l) begin
                        m0_ack <= ~owner;
                        m1_ack <= owner;
                        state  <= ACK;
                    end else begin
                        cnt   <= CNT_W'(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // Last wait cycle: RAM output now reflects the registered address.
                    if (cnt == 3'd1) begin
                        if (owner) m1_rdata <= ram_rdata;
                        else       m0_rdata <= ram_rdata;
                        m0_ack <= ~owner;
                        m1_ack <= owner;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model and a RAM model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;

    logic CLOCK_50 = 1'b0;
    logic reset;
    logic              r_req   [2];
    logic              r_we    [2];
    logic [ADDR_W-1:0] r_addr  [2];
    logic [DATA_W-1:0] r_wdata [2];
    logic              m0_ack, m1_ack, ram_we, busy, owner;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
    logic [ADDR_W-1:0] ram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .m0_req(r_req[0]), .m0_we(r_we[0]), .m0_addr(r_addr[0]), .m0_wdata(r_wdata[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(r_req[1]), .m1_we(r_we[1]), .m1_addr(r_addr[1]), .m1_wdata(r_wdata[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .busy(busy), .owner(owner)
    );

    // RAM with RD_LAT cycles from address to data
    logic [DATA_W-1:0] mem   [512];
    logic [DATA_W-1:0] rpipe [RD_LAT];
    always @(posedge CLOCK_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rpipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, outputs derived from cycles since grant
    logic [DATA_W-1:0] shadow [512];
    int                cyc = 0;
    bit                m_active;
    int                m_start, m_len, k;
    bit                m_own, m_we, e_owner, e_last;
    logic [DATA_W-1:0] m_rd, e_wdata;
    logic [DATA_W-1:0] e_rdata [2];
    logic [ADDR_W-1:0] e_addr;
    bit                e_busy, e_rwe, e_ack0, e_ack1, g;
    bit                rec_en = 1'b0;
    int                ack_q [$];

    task automatic model_reset();
        m_active = 1'b0; e_owner = 1'b0; e_last = 1'b1;
        e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    endtask

    always @(negedge CLOCK_50) begin
        if (reset) begin
            model_reset();
        end else begin
            cyc++;
            e_busy = 1'b0; e_rwe = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0; k = 0;
            if (m_active) begin
                k      = cyc - m_start;
                e_busy = 1'b1;
                e_rwe  = (k == 1) && m_we;
                if (k == m_len) begin
                    if (!m_we) e_rdata[m_own] = m_rd;
                    e_ack0 = !m_own;
                    e_ack1 = m_own;
                end
            end
            chk("cyc_m0_ack", 32'(m0_ack), 32'(e_ack0));
            chk("cyc_m1_ack", 32'(m1_ack), 32'(e_ack1));
            chk("cyc_ram_we", 32'(ram_we), 32'(e_rwe));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            chk("cyc_owner", 32'(owner), 32'(e_owner));
            chk("cyc_ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("cyc_ram_wdata", ram_wdata, e_wdata);
            chk("cyc_m0_rdata", m0_rdata, e_rdata[0]);
            chk("cyc_m1_rdata", m1_rdata, e_rdata[1]);
            if (rec_en && (m0_ack || m1_ack)) ack_q.push_back(m1_ack ? 1 : 0);
            if (m_active && k == m_len) begin
                m_active = 1'b0;
            end else if (!m_active && (r_req[0] || r_req[1])) begin
`ifdef ARB_CPU_PRIORITY_EN
                g = !r_req[0];
`else
                g = (r_req[0] && r_req[1]) ? !e_last : r_req[1];
`endif
                m_active = 1'b1; m_start = cyc; m_own = g; m_we = r_we[g];
                m_len    = m_we ? 2 : 2 + RD_LAT;
                e_owner  = g; e_last = g;
                e_addr   = r_addr[g]; e_wdata = r_wdata[g];
                m_rd     = shadow[r_addr[g]];
                if (m_we) shadow[r_addr[g]] = r_wdata[g];
            end
        end
    end

    function automatic logic ack_of(input int id);
        return (id == 0) ? m0_ack : m1_ack;
    endfunction

    // One transaction; lat counts cycles from the first IDLE cycle with req high
    task automatic single(input int id, input bit w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int lat, output int nwe,
                          output logic [ADDR_W-1:0] we_addr, output int other);
        @(posedge CLOCK_50); #1;
        r_req[id] = 1'b1; r_we[id] = w; r_addr[id] = a; r_wdata[id] = d;
        lat = -1; nwe = 0; other = 0; we_addr = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLOCK_50);
            if (ram_we) begin nwe++; we_addr = ram_addr; end
            if (ack_of(1 - id)) other++;
            if (ack_of(id)) begin lat = c; break; end
        end
        @(posedge CLOCK_50); #1;
        r_req[id] = 1'b0;
    endtask

    // Streams n transactions; directed mode issues writes to 2*t+id
    task automatic requester(input int id, input int n, input int idle_max, input bit directed);
        bit got;
        for (int t = 0; t < n; t++) begin
            r_req[id]   = 1'b1;
            r_we[id]    = directed ? 1'b1 : 1'($urandom_range(0, 1));
            r_addr[id]  = directed ? ADDR_W'(2 * t + id) : ADDR_W'($urandom_range(0, 15));
            r_wdata[id] = $urandom;
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge CLOCK_50);
                got = ack_of(id);
            end
            if (!got) chk("req_timeout", 32'(got), 32'd1);
            @(posedge CLOCK_50); #1;
            r_req[id] = 1'b0;
            repeat ($urandom_range(0, idle_max)) begin @(posedge CLOCK_50); #1; end
        end
    endtask

    int lat, nwe, other, cnt;
    logic [ADDR_W-1:0] wa;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 32'hA500_0000 | 32'(i);
            shadow[i] = 32'hA500_0000 | 32'(i);
        end
        mem[9'h1FF] = 32'h0000_0080; shadow[9'h1FF] = 32'h0000_0080;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_m0_ack", 32'(m0_ack), 0);
        chk("rst_m1_ack", 32'(m1_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        @(posedge CLOCK_50); #1;
        reset = 1'b0;

        single(0, 1'b1, 9'h012, 32'hDEADBEEF, lat, nwe, wa, other);
        chk("wr_ack_cycle", 32'(lat), 2);
        chk("wr_we_cycles", 32'(nwe), 1);
        chk("wr_we_addr", 32'(wa), 32'h012);
        chk("wr_m1_ack_quiet", 32'(other), 0);

        single(1, 1'b0, 9'h012, 32'h0, lat, nwe, wa, other);
        chk("rd1_ack_cycle", 32'(lat), 2 + RD_LAT);
        chk("rd1_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("rd1_m0_rdata", m0_rdata, 32'h0);
        chk("rd1_we_cycles", 32'(nwe), 0);

        single(0, 1'b0, 9'h1FF, 32'h0, lat, nwe, wa, other);
        chk("rd0_ack_cycle", 32'(lat), 2 + RD_LAT);
        chk("rd0_m0_rdata", m0_rdata, 32'h0000_0080);

        // Reset while an m1 read sits in WAIT
        @(posedge CLOCK_50); #1;
        r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 9'h012;
        repeat (3) @(negedge CLOCK_50);
        #2 reset = 1'b1; r_req[1] = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ram_we", 32'(ram_we), 0);
        chk("arst_m1_rdata", m1_rdata, 0);
        chk("arst_m1_ack", 32'(m1_ack), 0);
        @(negedge CLOCK_50);
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin @(negedge CLOCK_50); if (m1_ack) cnt++; end
        chk("arst_no_ack", 32'(cnt), 0);
        single(1, 1'b0, 9'h012, 32'h0, lat, nwe, wa, other);
        chk("rerq_ack_cycle", 32'(lat), 2 + RD_LAT);
        chk("rerq_m1_rdata", m1_rdata, 32'hDEADBEEF);

        // Both requesters held high: 4 writes each
        @(posedge CLOCK_50); #1;
        ack_q.delete();
        rec_en = 1'b1;
        fork
            requester(0, 4, 0, 1'b1);
            requester(1, 4, 0, 1'b1);
        join
        rec_en = 1'b0;
        chk("fair_count", 32'(ack_q.size()), 8);
        for (int i = 0; i < 8 && i < ack_q.size(); i++) begin
`ifdef ARB_CPU_PRIORITY_EN
            chk("prio_grant_order", 32'(ack_q[i]), (i < 4) ? 0 : 1);
`else
            chk("fair_grant_order", 32'(ack_q[i]), 32'(i % 2));
`endif
        end

        // Randomized traffic
        fork
            requester(0, 40, 3, 1'b0);
            requester(1, 40, 3, 1'b0);
        join
        repeat (4) @(posedge CLOCK_50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
